mem_arbiter: RTL

Two-requester arbiter sharing the single-port word memory (sp_mem) between the instruction fetch unit and the data (load/store) port. It grants at most one memory access per cycle and drives the memory's read or write strobe. It routes the 1-cycle-latency read data back to the owning requester. Data accesses have priority; an instruction fetch that keeps losing is guaranteed service after a bounded number of cycles.

---
 rtl/mem_arb_pkg.sv | 14 +
 rtl/mem_arbiter.sv | 98 +++++++++
 2 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the instruction/data memory arbiter.
// Response owner encoding plus the address widths of the requester and memory sides.
package mem_arb_pkg;

    localparam int ADDR_W      = 32;
    localparam int WORD_ADDR_W = 30;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_INS  = 2'd1,
        OWN_DATA = 2'd2
    } owner_t;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates the fetch unit and the LSU onto one single-port word memory.
// Data has priority; a fetch denied STARVE_LIMIT cycles in a row wins the next one.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,

    input  logic                   ins_req_i,
    input  logic [ADDR_W-1:0]      ins_addr_i,
    output logic                   ins_gnt_o,
    output logic                   ins_rvalid_o,
    output logic [31:0]            ins_rdata_o,

    input  logic                   data_req_i,
    input  logic                   data_we_i,
    input  logic [ADDR_W-1:0]      data_addr_i,
    input  logic [31:0]            data_wdata_i,
    output logic                   data_gnt_o,
    output logic                   data_rvalid_o,
    output logic [31:0]            data_rdata_o,

    output logic                   mem_read_o,
    output logic [WORD_ADDR_W-1:0] mem_raddr_o,
    input  logic [31:0]            mem_rdata_i,
    output logic                   mem_write_o,
    output logic [WORD_ADDR_W-1:0] mem_waddr_o,
    output logic [31:0]            mem_wdata_o
);

    localparam int                CNT_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] starve_cnt;
    owner_t           resp_owner;
    owner_t           owner_nxt;
    logic             ins_force;

    // Byte offsets are meaningless for a word memory.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{ins_addr_i[1:0], data_addr_i[1:0]};

    always_comb begin
        ins_gnt_o   = 1'b0;
        data_gnt_o  = 1'b0;
        mem_read_o  = 1'b0;
        mem_raddr_o = '0;
        mem_write_o = 1'b0;
        mem_waddr_o = '0;
        mem_wdata_o = '0;
        owner_nxt   = OWN_NONE;
        ins_force   = ins_req_i && (starve_cnt == CNT_MAX);

        if (!rst_i) begin
            if (ins_req_i && (ins_force || !data_req_i)) begin
                ins_gnt_o   = 1'b1;
                mem_read_o  = 1'b1;
                mem_raddr_o = ins_addr_i[ADDR_W-1:2];
                owner_nxt   = OWN_INS;
            end else if (data_req_i) begin
                data_gnt_o = 1'b1;
                if (data_we_i) begin
                    mem_write_o = 1'b1;
                    mem_waddr_o = data_addr_i[ADDR_W-1:2];
                    mem_wdata_o = data_wdata_i;
                end else begin
                    mem_read_o  = 1'b1;
                    mem_raddr_o = data_addr_i[ADDR_W-1:2];
                    owner_nxt   = OWN_DATA;
                end
            end
        end
    end

    // Owner tracks the read granted last cycle; writes leave nothing in flight.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            resp_owner <= OWN_NONE;
            starve_cnt <= '0;
        end else begin
            resp_owner <= owner_nxt;
            if (ins_req_i && !ins_gnt_o) begin
                if (starve_cnt != CNT_MAX)
                    starve_cnt <= starve_cnt + 1'b1;
            end else begin
                starve_cnt <= '0;
            end
        end
    end

    assign ins_rvalid_o  = (resp_owner == OWN_INS);
    assign data_rvalid_o = (resp_owner == OWN_DATA);
    assign ins_rdata_o   = ins_rvalid_o  ? mem_rdata_i : '0;
    assign data_rdata_o  = data_rvalid_o ? mem_rdata_i : '0;

endmodule
